// File: rtl/branch_target_buffer_pkg.sv
// Shared predictor definitions: index width, default PC width and the
// weakly-not-taken counter code used on re-allocation.
`default_nettype none

package branch_target_buffer_pkg;
  localparam int         PC_W_DEFAULT = 32;
  localparam int         IDX_W        = 8;
  localparam logic [1:0] WNT          = 2'b01;

  typedef logic [IDX_W-1:0] idx_t;
endpackage

`default_nettype wire

// File: rtl/branch_target_buffer_victim_select.sv
// Picks the allocation slot: lowest-index invalid entry, else the round-robin pointer.
`default_nettype none

module branch_target_buffer_victim_select
  import branch_target_buffer_pkg::*;
#(
  parameter int ENTRIES = 4
) (
  input  logic [ENTRIES-1:0] i_valid,
  input  idx_t               i_rr_ptr,
  output idx_t               o_victim,
  output logic               o_evict
);

  // Descending scan so the lowest invalid index is the last one written.
  always_comb begin
    o_victim = i_rr_ptr;
    o_evict  = 1'b1;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!i_valid[i]) begin
        o_victim = idx_t'(i);
        o_evict  = 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/branch_target_buffer.sv
// Fully associative PC/target table feeding a 2-bit counter array: combinational
// fetch lookup, registered train/re-init pulses on the resolve side.
`default_nettype none

module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int PC_W    = PC_W_DEFAULT,
  parameter int ENTRIES = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [PC_W-1:0] i_lookup_pc,
  input  logic            i_prediction,
  output logic            o_hit,
  output logic            o_redirect,
  output logic [PC_W-1:0] o_redirect_pc,
  output logic            o_get,
  output idx_t            o_get_index,
  input  logic            i_upd_valid,
  input  logic [PC_W-1:0] i_upd_pc,
  input  logic            i_upd_taken,
  input  logic [PC_W-1:0] i_upd_target,
  input  logic            i_flush,
  output logic            o_set,
  output idx_t            o_set_index,
  output logic            o_feedback,
  output logic            o_reset,
  output idx_t            o_reset_index
);

  logic [ENTRIES-1:0] r_valid;
  logic [PC_W-1:0]    r_tag    [ENTRIES];
  logic [PC_W-1:0]    r_target [ENTRIES];
  idx_t               r_rr_ptr;
  logic               r_set, r_feedback, r_reset;
  idx_t               r_set_index, r_reset_index;

  logic            w_lk_hit, w_up_hit, w_evict;
  idx_t            w_lk_idx, w_up_idx, w_victim;
  logic [PC_W-1:0] w_lk_target;

  // Two comparator banks; descending scans give lowest-index priority.
  always_comb begin
    w_lk_hit    = 1'b0;
    w_lk_idx    = '0;
    w_lk_target = '0;
    w_up_hit    = 1'b0;
    w_up_idx    = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_tag[i] == i_lookup_pc)) begin
        w_lk_hit    = 1'b1;
        w_lk_idx    = idx_t'(i);
        w_lk_target = r_target[i];
      end
      if (r_valid[i] && (r_tag[i] == i_upd_pc)) begin
        w_up_hit = 1'b1;
        w_up_idx = idx_t'(i);
      end
    end
  end

  branch_target_buffer_victim_select #(
    .ENTRIES (ENTRIES)
  ) u_victim_select (
    .i_valid  (r_valid),
    .i_rr_ptr (r_rr_ptr),
    .o_victim (w_victim),
    .o_evict  (w_evict)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_valid       <= '0;
      r_rr_ptr      <= '0;
      r_set         <= 1'b0;
      r_reset       <= 1'b0;
      r_feedback    <= 1'b0;
      r_set_index   <= '0;
      r_reset_index <= '0;
    end else begin
      r_set   <= 1'b0;
      r_reset <= 1'b0;
      if (i_flush) begin
        r_valid  <= '0;
        r_rr_ptr <= '0;
      end else if (i_upd_valid) begin
        if (w_up_hit) begin
          r_set       <= 1'b1;
          r_set_index <= w_up_idx;
          r_feedback  <= i_upd_taken;
          for (int i = 0; i < ENTRIES; i++) begin
            if (i_upd_taken && (idx_t'(i) == w_up_idx)) r_target[i] <= i_upd_target;
          end
        end else if (i_upd_taken) begin
          r_reset       <= 1'b1;
          r_reset_index <= w_victim;
          for (int i = 0; i < ENTRIES; i++) begin
            if (idx_t'(i) == w_victim) begin
              r_valid[i]  <= 1'b1;
              r_tag[i]    <= i_upd_pc;
              r_target[i] <= i_upd_target;
            end
          end
          // Pointer only advances when a live entry is displaced.
          if (w_evict) begin
            r_rr_ptr <= (r_rr_ptr == idx_t'(ENTRIES - 1)) ? '0 : r_rr_ptr + idx_t'(1);
          end
        end
      end
    end
  end

  assign o_hit         = w_lk_hit;
  assign o_get         = w_lk_hit;
  assign o_get_index   = w_lk_idx;
  assign o_redirect_pc = w_lk_target;
  assign o_redirect    = w_lk_hit & i_prediction;
  assign o_set         = r_set;
  assign o_set_index   = r_set_index;
  assign o_feedback    = r_feedback;
  assign o_reset       = r_reset;
  assign o_reset_index = r_reset_index;

endmodule

`default_nettype wire

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer with a behavioural table and counter model.
`default_nettype none

module tb_branch_target_buffer;
  import branch_target_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] lookup_pc = '0;
  logic        prediction;
  logic        hit, redirect, get, set_o, feedback, reset_o;
  logic [31:0] redirect_pc;
  logic [7:0]  get_index, set_index, reset_index;
  logic        upd_valid = 1'b0, upd_taken = 1'b0, flush = 1'b0;
  logic [31:0] upd_pc = '0, upd_target = '0;

  typedef struct packed {
    logic       set;
    logic [7:0] sidx;
    logic       fb;
    logic       rst;
    logic [7:0] ridx;
  } exp_t;
  exp_t q[$];

  int          n_cmp = 0;
  int          n_err = 0;
  logic        m_valid [4];
  logic [31:0] m_tag   [4];
  logic [31:0] m_tgt   [4];
  int          m_rr;
  logic [1:0]  ctr     [4];

  always #5 clk = ~clk;

  branch_target_buffer #(.PC_W(32), .ENTRIES(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_lookup_pc   (lookup_pc),
    .i_prediction  (prediction),
    .o_hit         (hit),
    .o_redirect    (redirect),
    .o_redirect_pc (redirect_pc),
    .o_get         (get),
    .o_get_index   (get_index),
    .i_upd_valid   (upd_valid),
    .i_upd_pc      (upd_pc),
    .i_upd_taken   (upd_taken),
    .i_upd_target  (upd_target),
    .i_flush       (flush),
    .o_set         (set_o),
    .o_set_index   (set_index),
    .o_feedback    (feedback),
    .o_reset       (reset_o),
    .o_reset_index (reset_index)
  );

  // Counter array environment: trains on set, re-initialises on reset.
  assign prediction = ctr[get_index[1:0]][1];
  always @(posedge clk) begin
    if (set_o) begin
      if (feedback && ctr[set_index[1:0]] != 2'b11) ctr[set_index[1:0]] <= ctr[set_index[1:0]] + 2'b01;
      else if (!feedback && ctr[set_index[1:0]] != 2'b00) ctr[set_index[1:0]] <= ctr[set_index[1:0]] - 2'b01;
    end else if (reset_o) begin
      ctr[reset_index[1:0]] <= WNT;
    end
  end

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    m_rr = 0;
    q.delete();
  endtask

  // One clock of update-port stimulus; expected pulses are queued then checked after the edge.
  task automatic step(input logic v, input logic [31:0] pc, input logic tk,
                      input logic [31:0] tg, input logic fl);
    exp_t e;
    int h, vic;
    @(negedge clk);
    upd_valid = v; upd_pc = pc; upd_taken = tk; upd_target = tg; flush = fl;
    e = '0;
    h = -1;
    for (int i = 3; i >= 0; i--) if (m_valid[i] && m_tag[i] == pc) h = i;
    if (fl) begin
      for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
      m_rr = 0;
    end else if (v) begin
      if (h >= 0) begin
        e.set = 1'b1; e.sidx = 8'(h); e.fb = tk;
        if (tk) m_tgt[h] = tg;
      end else if (tk) begin
        vic = -1;
        for (int i = 3; i >= 0; i--) if (!m_valid[i]) vic = i;
        if (vic < 0) begin
          vic = m_rr;
          m_rr = (m_rr + 1) % 4;
        end
        m_valid[vic] = 1'b1; m_tag[vic] = pc; m_tgt[vic] = tg;
        e.rst = 1'b1; e.ridx = 8'(vic);
      end
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    upd_valid = 1'b0; flush = 1'b0;
    e = q.pop_front();
    n_cmp++;
    if (set_o !== e.set) begin n_err++; $display("FAIL set pc=%h got %b exp %b", pc, set_o, e.set); end
    n_cmp++;
    if (reset_o !== e.rst) begin n_err++; $display("FAIL reset pc=%h got %b exp %b", pc, reset_o, e.rst); end
    if (e.set) begin
      n_cmp++;
      if (set_index !== e.sidx || feedback !== e.fb) begin
        n_err++; $display("FAIL set_index/feedback pc=%h got %0d/%b exp %0d/%b", pc, set_index, feedback, e.sidx, e.fb);
      end
    end
    if (e.rst) begin
      n_cmp++;
      if (reset_index !== e.ridx) begin n_err++; $display("FAIL reset_index pc=%h got %0d exp %0d", pc, reset_index, e.ridx); end
    end
  endtask

  task automatic lookup_check(input logic [31:0] pc);
    int h;
    logic [31:0] et;
    lookup_pc = pc;
    #1;
    h = -1;
    for (int i = 3; i >= 0; i--) if (m_valid[i] && m_tag[i] == pc) h = i;
    et = (h >= 0) ? m_tgt[h] : 32'h0;
    n_cmp++;
    if (hit !== (h >= 0) || get !== (h >= 0)) begin n_err++; $display("FAIL hit/get pc=%h got %b/%b exp %b", pc, hit, get, h >= 0); end
    n_cmp++;
    if (get_index !== ((h >= 0) ? 8'(h) : 8'd0)) begin n_err++; $display("FAIL get_index pc=%h got %0d exp %0d", pc, get_index, h); end
    n_cmp++;
    if (redirect_pc !== et) begin n_err++; $display("FAIL redirect_pc pc=%h got %h exp %h", pc, redirect_pc, et); end
    n_cmp++;
    if (redirect !== ((h >= 0) && ctr[h[1:0]][1])) begin n_err++; $display("FAIL redirect pc=%h got %b", pc, redirect); end
  endtask

  task automatic test_reset();
    @(negedge clk); reset_n = 1'b0;
    @(posedge clk); #1; reset_n = 1'b1;
    model_clear();
    n_cmp++;
    if (set_o !== 1'b0 || reset_o !== 1'b0) begin n_err++; $display("FAIL reset_pulses got set=%b reset=%b exp 0/0", set_o, reset_o); end
    lookup_check(32'h100);
  endtask

  task automatic test_allocate();
    step(1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
    lookup_check(32'h100);
  endtask

  task automatic test_train();
    step(1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
    step(1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    lookup_pc = 32'h100; #1;
    n_cmp++;
    if (redirect !== 1'b1) begin n_err++; $display("FAIL train_redirect got %b exp 1", redirect); end
    lookup_check(32'h100);
  endtask

  task automatic test_replace();
    step(1'b1, 32'h200, 1'b1, 32'h1200, 1'b0);
    step(1'b1, 32'h300, 1'b1, 32'h1300, 1'b0);
    step(1'b1, 32'h400, 1'b1, 32'h1400, 1'b0);
    step(1'b1, 32'h500, 1'b1, 32'h1500, 1'b0);
    n_cmp++;
    if (reset_index !== 8'd0) begin n_err++; $display("FAIL evict_first got %0d exp 0", reset_index); end
    lookup_check(32'h100);
    step(1'b1, 32'h600, 1'b1, 32'h1600, 1'b0);
    n_cmp++;
    if (reset_index !== 8'd1) begin n_err++; $display("FAIL evict_second got %0d exp 1", reset_index); end
    step(1'b1, 32'h800, 1'b1, 32'h1800, 1'b0);
    step(1'b1, 32'h900, 1'b1, 32'h1900, 1'b0);
    step(1'b1, 32'hA00, 1'b1, 32'h1A00, 1'b0);
    n_cmp++;
    if (reset_index !== 8'd0) begin n_err++; $display("FAIL rr_wrap got %0d exp 0", reset_index); end
    step(1'b1, 32'hB00, 1'b1, 32'h1B00, 1'b0);
    for (int i = 0; i < 12; i++) lookup_check(32'h100 * i);
  endtask

  task automatic test_not_taken();
    step(1'b1, 32'h700, 1'b0, 32'h1700, 1'b0);
    lookup_check(32'h700);
    step(1'b1, 32'h900, 1'b0, 32'h2900, 1'b0);
    lookup_pc = 32'h900; #1;
    n_cmp++;
    if (redirect_pc !== 32'h1900) begin n_err++; $display("FAIL nt_target_kept got %h exp 00001900", redirect_pc); end
    lookup_check(32'h900);
  endtask

  task automatic test_flush_and_reset();
    step(1'b1, 32'hC00, 1'b1, 32'h1C00, 1'b1);
    for (int i = 8; i < 13; i++) lookup_check(32'h100 * i);
    step(1'b1, 32'h100, 1'b1, 32'h300, 1'b0);
    lookup_check(32'h100);
    step(1'b1, 32'h200, 1'b1, 32'h400, 1'b0);
    @(negedge clk); reset_n = 1'b0;
    @(posedge clk); #1; reset_n = 1'b1;
    model_clear();
    n_cmp++;
    if (reset_o !== 1'b0 || set_o !== 1'b0) begin n_err++; $display("FAIL midstream_reset got set=%b reset=%b exp 0/0", set_o, reset_o); end
    lookup_check(32'h100);
    lookup_check(32'h200);
  endtask

  task automatic test_back_to_back();
    step(1'b1, 32'hD00, 1'b1, 32'h1D00, 1'b0);
    step(1'b1, 32'hD00, 1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    lookup_check(32'hD00);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      ctr[i] = WNT; m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0;
    end
    m_rr = 0;
    test_reset();
    test_allocate();
    test_train();
    test_replace();
    test_not_taken();
    test_flush_and_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
